// File: rtl/pipe_ctrl_if.sv
// rtl/pipe_ctrl_if.sv - pipeline control bundle: hazard inputs and per-latch enable/flush
interface pipe_ctrl_if;
    logic       ihit;
    logic       dhit;
    logic       dmem_req;
    logic       ex_load;
    logic [4:0] ex_rt;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_uses_rt;
    logic       redirect;
    logic       mem_halt;

    logic       pc_en;
    logic       ifid_en;
    logic       idex_en;
    logic       exmem_en;
    logic       memwb_en;
    logic       ifid_flush;
    logic       idex_flush;
    logic       exmem_flush;
    logic       memwb_flush;

    // Controller side: consumes hazard information, drives latch controls.
    modport master (
        input  ihit, dhit, dmem_req, ex_load, ex_rt, id_rs, id_rt,
               id_uses_rt, redirect, mem_halt,
        output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
               ifid_flush, idex_flush, exmem_flush, memwb_flush
    );

    // Pipeline side: reports hazards, obeys latch controls.
    modport slave (
        output ihit, dhit, dmem_req, ex_load, ex_rt, id_rs, id_rt,
               id_uses_rt, redirect, mem_halt,
        input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
               ifid_flush, idex_flush, exmem_flush, memwb_flush
    );
endinterface

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - five-stage pipeline stall/flush controller with halt drain and event counters
module pipe_ctrl #(
    parameter int CNT_W        = 16,
    parameter int DRAIN_CYCLES = 1
) (
    input  logic             CLK,
    input  logic             nRST,
    pipe_ctrl_if.master      pif,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_t;

    localparam logic [3:0]       DRAIN_LAST = 4'(DRAIN_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    state_t     state_q, state_d;
    logic [3:0] drain_q, drain_d;

    logic dstall;
    logic load_use;
    logic stall_inc;
    logic flush_inc;

    logic pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic ifid_flush, idex_flush, exmem_flush, memwb_flush;

    assign dstall   = pif.dmem_req & ~pif.dhit;
    assign load_use = pif.ex_load & (pif.ex_rt != 5'd0) &
                      ((pif.ex_rt == pif.id_rs) |
                       (pif.id_uses_rt & (pif.ex_rt == pif.id_rt)));

    // State, drain counter and halted flag; halted follows the next state so it rises with HALTED.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= RUN;
            drain_q <= 4'd0;
            halted  <= 1'b0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
            halted  <= (state_d == HALTED);
        end
    end

    // Next state and latch controls; everything is held at zero while reset is asserted.
    always_comb begin
        state_d     = state_q;
        drain_d     = drain_q;
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        idex_en     = 1'b0;
        exmem_en    = 1'b0;
        memwb_en    = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        memwb_flush = 1'b0;
        stall_inc   = 1'b0;
        flush_inc   = 1'b0;
        if (nRST) begin
            unique case (state_q)
                RUN: begin
                    if (pif.mem_halt) begin
                        // Let the halt itself retire into WB, freeze everything upstream.
                        memwb_en = 1'b1;
                        state_d  = DRAIN;
                        drain_d  = 4'd0;
                    end else if (dstall) begin
                        // EX/MEM holds the access; WB receives a bubble. A pending
                        // redirect stays asserted because EX is frozen.
                        memwb_en    = 1'b1;
                        memwb_flush = 1'b1;
                        stall_inc   = 1'b1;
                    end else if (pif.redirect) begin
                        // Squash the two younger instructions; an outstanding
                        // fetch or load-use is irrelevant once they are gone.
                        pc_en      = 1'b1;
                        ifid_flush = 1'b1;
                        idex_flush = 1'b1;
                        exmem_en   = 1'b1;
                        memwb_en   = 1'b1;
                        flush_inc  = 1'b1;
                    end else if (load_use) begin
                        idex_flush = 1'b1;
                        exmem_en   = 1'b1;
                        memwb_en   = 1'b1;
                        stall_inc  = 1'b1;
                    end else if (!pif.ihit) begin
                        ifid_flush = 1'b1;
                        idex_en    = 1'b1;
                        exmem_en   = 1'b1;
                        memwb_en   = 1'b1;
                        stall_inc  = 1'b1;
                    end else begin
                        pc_en    = 1'b1;
                        ifid_en  = 1'b1;
                        idex_en  = 1'b1;
                        exmem_en = 1'b1;
                        memwb_en = 1'b1;
                    end
                end
                DRAIN: begin
                    memwb_en = (drain_q == 4'd0);
                    if (drain_q == DRAIN_LAST) begin
                        state_d = HALTED;
                    end else begin
                        drain_d = drain_q + 4'd1;
                    end
                end
                HALTED: begin
                    state_d = HALTED;
                end
                default: begin
                    state_d = RUN;
                end
            endcase
        end
    end

    assign pif.pc_en       = pc_en;
    assign pif.ifid_en     = ifid_en;
    assign pif.idex_en     = idex_en;
    assign pif.exmem_en    = exmem_en;
    assign pif.memwb_en    = memwb_en;
    assign pif.ifid_flush  = ifid_flush;
    assign pif.idex_flush  = idex_flush;
    assign pif.exmem_flush = exmem_flush;
    assign pif.memwb_flush = memwb_flush;

    // Saturating stall and redirect counters; increments only ever come from RUN.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_inc && (stall_cnt != CNT_MAX)) begin
                stall_cnt <= stall_cnt + CNT_ONE;
            end
            if (flush_inc && (flush_cnt != CNT_MAX)) begin
                flush_cnt <= flush_cnt + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - self-checking bench for pipe_ctrl
module tb_pipe_ctrl;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        halted, halted_s;
    logic [15:0] stall_cnt, flush_cnt;
    logic [3:0]  stall_s, flush_s;

    always #5 CLK = ~CLK;

    pipe_ctrl_if pif ();
    pipe_ctrl_if sif ();

    pipe_ctrl #(.CNT_W(16), .DRAIN_CYCLES(1)) u_dut (
        .CLK(CLK), .nRST(nRST), .pif(pif.master),
        .halted(halted), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    pipe_ctrl #(.CNT_W(4), .DRAIN_CYCLES(1)) u_sat (
        .CLK(CLK), .nRST(nRST), .pif(sif.master),
        .halted(halted_s), .stall_cnt(stall_s), .flush_cnt(flush_s)
    );

    // {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_fl, idex_fl, exmem_fl, memwb_fl}
    localparam logic [8:0] O_NORM  = 9'b11111_0000;
    localparam logic [8:0] O_DST   = 9'b00001_0001;
    localparam logic [8:0] O_REDIR = 9'b10011_1100;
    localparam logic [8:0] O_LU    = 9'b00011_0100;
    localparam logic [8:0] O_IMISS = 9'b00111_1000;
    localparam logic [8:0] O_WB    = 9'b00001_0000;
    localparam logic [8:0] O_ZERO  = 9'b00000_0000;

    typedef struct {
        logic       ihit, dhit, dmem_req, ex_load;
        logic [4:0] ex_rt, id_rs, id_rt;
        logic       id_uses_rt, redirect, mem_halt;
        logic [8:0] exp;
        logic       inc_s, inc_f;
    } vec_t;

    typedef struct {
        string       name;
        logic [8:0]  out;
        logic [15:0] sc, fc;
        logic [3:0]  ssc, sfc;
        logic        h;
    } sb_t;

    sb_t         sbq[$];
    int          compared   = 0;
    int          mismatched = 0;
    logic [15:0] m_sc, m_fc;
    logic [3:0]  m_ssc, m_sfc;

    function automatic vec_t mk(input logic ihit, dhit, dmem_req, ex_load,
                                input logic [4:0] ex_rt, id_rs, id_rt,
                                input logic uses_rt, redirect, mem_halt,
                                input logic [8:0] exp, input logic inc_s, inc_f);
        vec_t v;
        v.ihit = ihit; v.dhit = dhit; v.dmem_req = dmem_req; v.ex_load = ex_load;
        v.ex_rt = ex_rt; v.id_rs = id_rs; v.id_rt = id_rt; v.id_uses_rt = uses_rt;
        v.redirect = redirect; v.mem_halt = mem_halt; v.exp = exp;
        v.inc_s = inc_s; v.inc_f = inc_f;
        return v;
    endfunction

    function automatic logic [8:0] outs_main();
        return {pif.pc_en, pif.ifid_en, pif.idex_en, pif.exmem_en, pif.memwb_en,
                pif.ifid_flush, pif.idex_flush, pif.exmem_flush, pif.memwb_flush};
    endfunction

    function automatic logic [8:0] outs_sat();
        return {sif.pc_en, sif.ifid_en, sif.idex_en, sif.exmem_en, sif.memwb_en,
                sif.ifid_flush, sif.idex_flush, sif.exmem_flush, sif.memwb_flush};
    endfunction

    task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        pif.ihit = v.ihit; pif.dhit = v.dhit; pif.dmem_req = v.dmem_req;
        pif.ex_load = v.ex_load; pif.ex_rt = v.ex_rt; pif.id_rs = v.id_rs;
        pif.id_rt = v.id_rt; pif.id_uses_rt = v.id_uses_rt;
        pif.redirect = v.redirect; pif.mem_halt = v.mem_halt;
        sif.ihit = v.ihit; sif.dhit = v.dhit; sif.dmem_req = v.dmem_req;
        sif.ex_load = v.ex_load; sif.ex_rt = v.ex_rt; sif.id_rs = v.id_rs;
        sif.id_rt = v.id_rt; sif.id_uses_rt = v.id_uses_rt;
        sif.redirect = v.redirect; sif.mem_halt = v.mem_halt;
    endtask

    task automatic check_front();
        sb_t e;
        if (sbq.size() == 0) begin
            cmp("scoreboard_empty", 16'd1, 16'd0);
        end else begin
            e = sbq.pop_front();
            cmp({e.name, "/outs"},     16'(outs_main()), 16'(e.out));
            cmp({e.name, "/outs_sat"}, 16'(outs_sat()),  16'(e.out));
            cmp({e.name, "/stall_cnt"}, stall_cnt, e.sc);
            cmp({e.name, "/flush_cnt"}, flush_cnt, e.fc);
            cmp({e.name, "/stall_sat"}, 16'(stall_s), 16'(e.ssc));
            cmp({e.name, "/flush_sat"}, 16'(flush_s), 16'(e.sfc));
            cmp({e.name, "/halted"},    16'(halted),   16'(e.h));
            cmp({e.name, "/halted_sat"}, 16'(halted_s), 16'(e.h));
        end
    endtask

    // Drive one cycle of inputs, record expectations, check at the falling edge.
    task automatic step(input string name, input vec_t v, input logic exp_h);
        sb_t e;
        drive(v);
        e.name = name; e.out = v.exp; e.sc = m_sc; e.fc = m_fc;
        e.ssc = m_ssc; e.sfc = m_sfc; e.h = exp_h;
        sbq.push_back(e);
        if (v.inc_s) begin
            m_sc = m_sc + 16'd1;
            if (m_ssc != 4'hF) m_ssc = m_ssc + 4'd1;
        end
        if (v.inc_f) begin
            m_fc = m_fc + 16'd1;
            if (m_sfc != 4'hF) m_sfc = m_sfc + 4'd1;
        end
        @(negedge CLK);
        check_front();
        @(posedge CLK);
        #1;
    endtask

    // Assert reset asynchronously, check it takes effect at once, release on a falling edge.
    task automatic do_reset(input string name);
        nRST = 1'b0;
        #1;
        cmp({name, "/outs"},      16'(outs_main()), 16'(O_ZERO));
        cmp({name, "/halted"},    16'(halted), 16'd0);
        cmp({name, "/stall_cnt"}, stall_cnt, 16'd0);
        cmp({name, "/flush_cnt"}, flush_cnt, 16'd0);
        cmp({name, "/stall_sat"}, 16'(stall_s), 16'd0);
        m_sc = '0; m_fc = '0; m_ssc = '0; m_sfc = '0;
        @(negedge CLK);
        nRST = 1'b1;
        @(posedge CLK);
        #1;
    endtask

    vec_t tbl[$];
    vec_t v_norm, v_imiss, v_halt, v_junk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        v_norm  = mk(1,0,0,0, 5'd0,5'd0,5'd0, 0,0,0, O_NORM,  0,0);
        v_imiss = mk(0,0,0,0, 5'd0,5'd0,5'd0, 0,0,0, O_IMISS, 1,0);
        v_halt  = mk(1,0,0,0, 5'd0,5'd0,5'd0, 0,0,1, O_WB,    0,0);
        v_junk  = mk(0,0,1,1, 5'd5,5'd5,5'd0, 0,1,1, O_ZERO,  0,0);

        //          ihit dhit dreq ld  ex_rt  id_rs  id_rt  urt red hlt  exp      s f
        tbl.push_back(mk(1,0,0,0, 5'd0, 5'd0, 5'd0, 0,0,0, O_NORM,  0,0));
        tbl.push_back(mk(1,0,0,1, 5'd5, 5'd5, 5'd0, 0,0,0, O_LU,    1,0));
        tbl.push_back(mk(1,0,0,1, 5'd0, 5'd0, 5'd0, 1,0,0, O_NORM,  0,0));
        tbl.push_back(mk(1,0,0,1, 5'd7, 5'd3, 5'd7, 1,0,0, O_LU,    1,0));
        tbl.push_back(mk(1,0,0,1, 5'd7, 5'd3, 5'd7, 0,0,0, O_NORM,  0,0));
        tbl.push_back(mk(0,0,0,0, 5'd0, 5'd0, 5'd0, 0,0,0, O_IMISS, 1,0));
        tbl.push_back(mk(1,0,1,0, 5'd0, 5'd0, 5'd0, 0,0,0, O_DST,   1,0));
        tbl.push_back(mk(1,0,1,0, 5'd0, 5'd0, 5'd0, 0,0,0, O_DST,   1,0));
        tbl.push_back(mk(1,0,1,0, 5'd0, 5'd0, 5'd0, 0,0,0, O_DST,   1,0));
        tbl.push_back(mk(1,1,1,0, 5'd0, 5'd0, 5'd0, 0,0,0, O_NORM,  0,0));
        tbl.push_back(mk(0,0,0,1, 5'd5, 5'd5, 5'd0, 0,1,0, O_REDIR, 0,1));
        tbl.push_back(mk(0,0,1,1, 5'd5, 5'd5, 5'd0, 0,1,0, O_DST,   1,0));
        tbl.push_back(mk(1,0,0,0, 5'd0, 5'd0, 5'd0, 0,0,0, O_NORM,  0,0));

        drive(v_norm);
        m_sc = '0; m_fc = '0; m_ssc = '0; m_sfc = '0;
        do_reset("reset_initial");

        foreach (tbl[i]) step($sformatf("vec%0d", i), tbl[i], 1'b0);

        step("halt_req", v_halt, 1'b0);
        step("drain", mk(1,0,0,0, 5'd0,5'd0,5'd0, 0,0,0, O_WB, 0,0), 1'b0);
        for (int i = 0; i < 3; i++) step($sformatf("halted%0d", i), v_junk, 1'b1);

        drive(v_norm);
        do_reset("reset_halted");
        step("after_reset_halted", v_norm, 1'b0);

        step("pre_halt_miss", v_imiss, 1'b0);
        step("halt_req2", v_halt, 1'b0);
        drive(v_norm);
        do_reset("reset_in_drain");
        step("after_reset_drain", v_norm, 1'b0);

        for (int i = 0; i < 20; i++) step($sformatf("sat%0d", i), v_imiss, 1'b0);
        step("sat_hold", v_norm, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
